// File: rtl/snitch_dma_pkg.sv
// Shared types for the DMA job scheduler: backend job descriptor and completion-order tag.
package snitch_dma_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned LenWidth  = 32;
  // Widest requester count the tag format is sized for (cluster NrDmaMasters).
  localparam int unsigned MaxReq      = 2;
  localparam int unsigned ReqIdxWidth = (MaxReq > 1) ? $clog2(MaxReq) : 1;

  typedef logic [AddrWidth-1:0]   addr_t;
  typedef logic [LenWidth-1:0]    len_t;
  typedef logic [ReqIdxWidth-1:0] req_idx_t;

  typedef struct packed {
    addr_t src;
    addr_t dst;
    len_t  len;
  } job_t;

  // One entry per accepted job, in accept order; zero-length jobs never reach the backend.
  typedef struct packed {
    req_idx_t req;
    logic     zero;
  } tag_t;

endpackage

// File: rtl/snitch_dma_job_sched_fifo.sv
// Completion-order tag FIFO (fifo_v3 style, synchronous reset, power-of-2 depth).
module snitch_dma_job_sched_fifo #(
  parameter int unsigned Depth     = 4,
  parameter int unsigned DataWidth = 8,
  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntWidth = $clog2(Depth) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 empty_o,
  output logic [CntWidth-1:0]  usage_o
);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0]  cnt_q;
  logic                 full, push_en, pop_en;

  assign full    = (cnt_q == CntWidth'(Depth));
  assign empty_o = (cnt_q == '0);
  assign usage_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign push_en = push_i && !full;
  assign pop_en  = pop_i && !empty_o;

  // Pointers and occupancy; pointers wrap naturally because Depth is a power of 2.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
      cnt_q <= cnt_q + CntWidth'(push_en) - CntWidth'(pop_en);
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/snitch_dma_job_sched.sv
// Round-robin job scheduler sharing one wide DMA backend among NumReq requesters,
// with an outstanding-job cap, per-requester IDs and in-order completion pulses.
module snitch_dma_job_sched
  import snitch_dma_pkg::*;
#(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned TxIdWidth      = 32,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned PtrWidth = (NumReq > 1) ? $clog2(NumReq) : 1,
  localparam int unsigned CntWidth = $clog2(MaxOutstanding) + 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumReq-1:0]                  req_valid_i,
  output logic [NumReq-1:0]                  req_ready_o,
  input  job_t [NumReq-1:0]                  req_job_i,
  output logic [NumReq-1:0][TxIdWidth-1:0]   req_id_o,
  output logic [NumReq-1:0]                  cpl_valid_o,
  output logic [NumReq-1:0][TxIdWidth-1:0]   cpl_id_o,
  output logic                               be_valid_o,
  input  logic                               be_ready_i,
  output job_t                               be_job_o,
  input  logic                               be_done_i,
  output logic                               busy_o,
  output logic                               err_o
);

  logic [PtrWidth-1:0]                rr_ptr_q, grant_idx, cand, head_idx;
  logic [NumReq-1:0][TxIdWidth-1:0]   id_cnt_q, cpl_cnt_q;
  logic [CntWidth-1:0]                tag_cnt, dcnt_q, icnt_q;
  logic                               be_valid_q, err_q;
  job_t                               be_job_q, gjob;
  logic                               grant_vld, accept, gzero;
  logic                               fifo_empty, done_ok, pop, pop_nz;
  tag_t                               head, push_tag;

  assign gjob     = req_job_i[grant_idx];
  assign gzero    = (gjob.len == '0);
  assign push_tag = '{req: req_idx_t'(grant_idx), zero: gzero};
  assign head_idx = PtrWidth'(head.req);

  // Done is only meaningful while an issued job is still waiting for it.
  assign done_ok = be_done_i && (icnt_q != '0);
  assign pop     = rst_ni && !fifo_empty && (head.zero || (dcnt_q != '0) || done_ok);
  assign pop_nz  = pop && !head.zero;

  assign req_id_o   = id_cnt_q;
  assign cpl_id_o   = cpl_cnt_q;
  assign be_valid_o = be_valid_q;
  assign be_job_o   = be_job_q;
  assign err_o      = err_q;
  assign busy_o     = (tag_cnt != '0) || be_valid_q;

  // Round-robin pick starting at rr_ptr; accept only with a free out-reg and a free tag slot.
  always_comb begin
    grant_vld   = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    accept      = 1'b0;
    req_ready_o = '0;
    for (int k = 0; k < int'(NumReq); k++) begin
      cand = PtrWidth'((32'(rr_ptr_q) + 32'(k)) % NumReq);
      if (!grant_vld && req_valid_i[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    accept = rst_ni && grant_vld && (!be_valid_q || be_ready_i)
             && (tag_cnt < CntWidth'(MaxOutstanding));
    if (accept) req_ready_o[grant_idx] = 1'b1;
  end

  // Completion pulse goes to the owner of the popped head tag.
  always_comb begin
    cpl_valid_o = '0;
    if (pop) cpl_valid_o[head_idx] = 1'b1;
  end

  // Arbiter pointer, ID counters, done/issue bookkeeping, backend output register, error flag.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      id_cnt_q   <= '0;
      cpl_cnt_q  <= '0;
      dcnt_q     <= '0;
      icnt_q     <= '0;
      be_valid_q <= 1'b0;
      be_job_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        rr_ptr_q            <= (grant_idx == PtrWidth'(NumReq - 1)) ? '0 : grant_idx + PtrWidth'(1);
        id_cnt_q[grant_idx] <= id_cnt_q[grant_idx] + TxIdWidth'(1);
      end
      if (pop) cpl_cnt_q[head_idx] <= cpl_cnt_q[head_idx] + TxIdWidth'(1);
      dcnt_q <= dcnt_q + CntWidth'(done_ok) - CntWidth'(pop_nz);
      icnt_q <= icnt_q + CntWidth'(be_valid_q && be_ready_i) - CntWidth'(done_ok);
      if (accept && !gzero) begin
        be_valid_q <= 1'b1;
        be_job_q   <= gjob;
      end else if (be_ready_i) begin
        be_valid_q <= 1'b0;
      end
      if (be_done_i && (icnt_q == '0)) err_q <= 1'b1;
    end
  end

  snitch_dma_job_sched_fifo #(
    .Depth     (MaxOutstanding),
    .DataWidth ($bits(tag_t))
  ) i_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (accept),
    .data_i  (push_tag),
    .pop_i   (pop),
    .data_o  (head),
    .empty_o (fifo_empty),
    .usage_o (tag_cnt)
  );

endmodule

// File: tb/tb_snitch_dma_job_sched.sv
// Directed bench for the DMA job scheduler (2 requesters, 2-bit IDs, 4 outstanding).
module tb_snitch_dma_job_sched;
  import snitch_dma_pkg::*;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic [1:0]           req_valid_i, req_ready_o, cpl_valid_o;
  job_t [1:0]           req_job_i;
  logic [1:0][1:0]      req_id_o, cpl_id_o;
  logic                 be_valid_o, be_ready_i, be_done_i, busy_o, err_o;
  job_t                 be_job_o;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc;

  snitch_dma_job_sched #(
    .NumReq         (2),
    .TxIdWidth      (2),
    .MaxOutstanding (4)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_job_i   (req_job_i),
    .req_id_o    (req_id_o),
    .cpl_valid_o (cpl_valid_o),
    .cpl_id_o    (cpl_id_o),
    .be_valid_o  (be_valid_o),
    .be_ready_i  (be_ready_i),
    .be_job_o    (be_job_o),
    .be_done_i   (be_done_i),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic job_t mk_job(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
    job_t j;
    j.src = s;
    j.dst = d;
    j.len = l;
    return j;
  endfunction

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset;
    rst_ni      = 1'b0;
    req_valid_i = '0;
    be_done_i   = 1'b0;
    be_ready_i  = 1'b1;
    step;
    step;
    rst_ni = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state, with requests already pending
    rst_ni      = 1'b0;
    be_ready_i  = 1'b1;
    be_done_i   = 1'b0;
    req_valid_i = 2'b11;
    req_job_i[0] = mk_job(32'h1000, 32'h2000, 32'd64);
    req_job_i[1] = mk_job(32'h3000, 32'h4000, 32'd64);
    step;
    #1;
    chk("rst_ready", req_ready_o, 2'b00);
    chk("rst_be_valid", be_valid_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_cpl_valid", cpl_valid_o, 2'b00);
    chk("rst_req_id", req_id_o, 4'h0);

    // 1: single req0 job
    do_reset;
    req_valid_i = 2'b01;
    #1;
    chk("t1_ready", req_ready_o, 2'b01);
    step;
    req_valid_i = 2'b00;
    #1;
    chk("t1_be_valid", be_valid_o, 1'b1);
    chk("t1_be_job", be_job_o, mk_job(32'h1000, 32'h2000, 32'd64));
    chk("t1_req_id0", req_id_o[0], 2'd1);
    chk("t1_busy", busy_o, 1'b1);
    step;
    be_done_i = 1'b1;
    #1;
    chk("t1_be_valid_drop", be_valid_o, 1'b0);
    chk("t1_cpl_valid", cpl_valid_o, 2'b01);
    chk("t1_cpl_id0", cpl_id_o[0], 2'd0);
    step;
    be_done_i = 1'b0;
    #1;
    chk("t1_cpl_clear", cpl_valid_o, 2'b00);
    chk("t1_idle", busy_o, 1'b0);

    // 2: both requesters saturating; grants alternate, completions 2 cycles behind accepts
    do_reset;
    for (int k = 0; k < 10; k++) begin
      req_valid_i = (k < 8) ? 2'b11 : 2'b00;
      be_done_i   = (k >= 2);
      #1;
      if (k < 8) chk("t2_grant", req_ready_o, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k >= 2) begin
        chk("t2_cpl_valid", cpl_valid_o, ((k - 2) % 2 == 0) ? 2'b01 : 2'b10);
        chk("t2_cpl_id", cpl_id_o[(k - 2) % 2], (k - 2) / 2);
      end
      step;
    end
    be_done_i = 1'b0;
    #1;
    // 4 jobs per requester with 2-bit IDs wraps back to 0
    chk("t2_req_id0", req_id_o[0], 2'd0);
    chk("t2_req_id1", req_id_o[1], 2'd0);
    chk("t2_idle", busy_o, 1'b0);
    chk("t2_err", err_o, 1'b0);

    // 3: outstanding cap, no same-cycle slot reuse
    do_reset;
    req_valid_i = 2'b11;
    n_acc = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_acc += $countones(req_ready_o);
      step;
    end
    chk("t3_accepted", n_acc, 4);
    #1;
    chk("t3_capped", req_ready_o, 2'b00);
    be_done_i = 1'b1;
    #1;
    chk("t3_no_reuse", req_ready_o, 2'b00);
    chk("t3_cpl", cpl_valid_o, 2'b01);
    step;
    be_done_i = 1'b0;
    #1;
    chk("t3_slot_freed", req_ready_o, 2'b01);
    step;

    // 4: zero-length job behind a real one
    do_reset;
    req_job_i[0] = mk_job(32'h5000, 32'h6000, 32'd128);
    req_job_i[1] = mk_job(32'h7000, 32'h8000, 32'd0);
    req_valid_i = 2'b01;
    #1;
    chk("t4_ready0", req_ready_o, 2'b01);
    step;
    req_valid_i = 2'b10;
    #1;
    chk("t4_ready1", req_ready_o, 2'b10);
    chk("t4_be_len", be_job_o.len, 32'd128);
    step;
    req_valid_i = 2'b00;
    #1;
    chk("t4_no_issue", be_valid_o, 1'b0);
    chk("t4_no_early_cpl", cpl_valid_o, 2'b00);
    step;
    #1;
    chk("t4_still_wait", cpl_valid_o, 2'b00);
    be_done_i = 1'b1;
    #1;
    chk("t4_cpl0", cpl_valid_o, 2'b01);
    step;
    be_done_i = 1'b0;
    #1;
    chk("t4_cpl1", cpl_valid_o, 2'b10);
    chk("t4_cpl_id1", cpl_id_o[1], 2'd0);
    step;
    #1;
    chk("t4_cpl_clear", cpl_valid_o, 2'b00);
    chk("t4_idle", busy_o, 1'b0);

    // 5: backend stall, then spurious done
    do_reset;
    be_ready_i = 1'b0;
    req_job_i[0] = mk_job(32'hA000, 32'hB000, 32'd32);
    req_job_i[1] = mk_job(32'hC000, 32'hD000, 32'd16);
    req_valid_i = 2'b01;
    #1;
    chk("t5_ready", req_ready_o, 2'b01);
    step;
    req_valid_i = 2'b10;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("t5_be_valid", be_valid_o, 1'b1);
      chk("t5_be_job", be_job_o, mk_job(32'hA000, 32'hB000, 32'd32));
      chk("t5_blocked", req_ready_o, 2'b00);
      step;
    end
    req_valid_i = 2'b00;
    be_done_i   = 1'b1;
    #1;
    chk("t5_done_ignored", cpl_valid_o, 2'b00);
    step;
    be_done_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t5_err_sticky", err_o, 1'b1);
      step;
    end

    // 6: reset mid-operation, then ID wrap
    do_reset;
    #1;
    chk("t6_err_cleared", err_o, 1'b0);
    req_valid_i = 2'b01;
    step;
    step;
    step;
    req_valid_i = 2'b00;
    #1;
    chk("t6_id3", req_id_o[0], 2'd3);
    chk("t6_busy", busy_o, 1'b1);
    rst_ni = 1'b0;
    step;
    chk("t6_be_valid", be_valid_o, 1'b0);
    chk("t6_busy_rst", busy_o, 1'b0);
    chk("t6_req_id", req_id_o, 4'h0);
    chk("t6_cpl_valid", cpl_valid_o, 2'b00);
    rst_ni = 1'b1;
    req_valid_i = 2'b01;
    step;
    step;
    step;
    #1;
    chk("t6_id_pre_wrap", req_id_o[0], 2'd3);
    step;
    req_valid_i = 2'b00;
    #1;
    chk("t6_id_wrap", req_id_o[0], 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
